// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexes DIGITS 7-segment patterns onto one shared
//            segment bus with per-digit anodes, frame snapshot, dead time,
//            per-digit enable mask and whole-display blink.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [8*DIGITS-1:0]   segs_i,
    input  logic [DIGITS-1:0]     en_mask_i,
    input  logic                  blink_i,
    output logic [7:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  c_dig_last = DIG_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  c_frm_last = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [DIV_W-1:0]  c_blank    = DIV_W'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0] c_one      = DIGITS'(1);

    logic [DIV_W-1:0]    r_div_cnt;
    logic [DIG_W-1:0]    r_digit;
    logic [FRM_W-1:0]    r_frame_cnt;
    logic                r_blink_phase;
    logic [8*DIGITS-1:0] r_snap;

    logic       w_div_wrap;
    logic       w_dig_wrap;
    logic       w_frm_wrap;
    logic       w_frame_start;
    logic       w_visible;
    logic       w_lit;
    logic [7:0] w_seg_sel;

    assign w_div_wrap    = (r_div_cnt == c_div_last);
    assign w_dig_wrap    = (r_digit == c_dig_last);
    assign w_frm_wrap    = (r_frame_cnt == c_frm_last);
    assign w_frame_start = (r_digit == '0) && (r_div_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div_cnt     <= '0;
            r_digit       <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_snap        <= '1;
        end else begin
            // Capture lands inside digit 0's blank window, so no frame tears.
            if (w_frame_start) begin
                r_snap <= segs_i;
            end
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                if (w_dig_wrap) begin
                    r_digit <= '0;
                    if (w_frm_wrap) begin
                        r_frame_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end else begin
                    r_digit <= r_digit + 1'b1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Mask and blink gate the outputs only; rst_i blanks them with no clock.
    assign w_seg_sel = r_snap[{r_digit, 3'b000} +: 8];
    assign w_visible = en_mask_i[r_digit] && !(blink_i && r_blink_phase);
    assign w_lit     = rst_i && w_visible && (r_div_cnt >= c_blank);

    assign seg_o   = w_lit ? w_seg_sel : 8'hFF;
    assign an_o    = w_lit ? ~(c_one << r_digit) : '1;
    assign frame_o = rst_i && w_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Scoreboard bench for seg_scan_driver against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int DIGITS       = 8;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [63:0] segs_i = '1;
    logic [7:0]  en_mask_i = 8'hFF;
    logic        blink_i = 1'b0;
    logic [7:0]  seg_o;
    logic [7:0]  an_o;
    logic        frame_o;

    seg_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .segs_i(segs_i), .en_mask_i(en_mask_i),
        .blink_i(blink_i), .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] seg;
        logic [7:0] an;
        logic       frame;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          t = 0;
    logic [63:0] snap_m = '1;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference: everything follows from the cycle index since reset release.
    function automatic exp_t model(input int tc, input logic [63:0] snap,
                                   input logic [7:0] m, input logic b);
        exp_t e;
        int   div, dig, phase;
        logic [7:0] tmp;
        div   = tc % SCAN_DIV;
        dig   = (tc / SCAN_DIV) % DIGITS;
        phase = ((tc / FRAME) / BLINK_FRAMES) % 2;
        e.frame = (tc % FRAME) == 0;
        e.cyc   = tc;
        if (div < BLANK_CYCLES || !m[dig] || (b && phase == 1)) begin
            e.seg = 8'hFF;
            e.an  = 8'hFF;
        end else begin
            e.seg = snap[dig*8 +: 8];
            tmp   = 8'h01 << dig;
            e.an  = ~tmp;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [63:0] s, input logic [7:0] m, input logic b);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i = r; segs_i = s; en_mask_i = m; blink_i = b;
        if (!r) begin
            t = 0;
            e.seg = 8'hFF; e.an = 8'hFF; e.frame = 1'b0; e.cyc = -1;
        end else begin
            if (t % FRAME == 0) snap_m = s;
            e = model(t, snap_m, m, b);
            t++;
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("seg_o",   e.cyc, {24'd0, seg_o}, {24'd0, e.seg});
                chk("an_o",    e.cyc, {24'd0, an_o},  {24'd0, e.an});
                chk("frame_o", e.cyc, {31'd0, frame_o}, {31'd0, e.frame});
            end
        end
    end

    initial begin : driver
        logic [63:0] ramp;
        logic [7:0]  m;
        logic        b;
        ramp = 64'h0706050403020100;

        // Reset hold, then release into the ramp pattern; switch to 0xC0 at cycle 20.
        repeat (3) step(1'b0, ramp, 8'hFF, 1'b0);
        for (int i = 0; i < 130; i++)
            step(1'b1, (t >= 20) ? {8{8'hC0}} : ramp, 8'hFF, 1'b0);

        // Mask 0x0F, widened to 0xFF from slot 4 div 4 of each frame.
        for (int i = 0; i < 2 * FRAME; i++)
            step(1'b1, {$urandom, $urandom}, (t % FRAME < 36) ? 8'h0F : 8'hFF, 1'b0);

        // Randomised segments, mask and blink.
        m = 8'hFF; b = 1'b0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0) m = 8'($urandom);
            if ($urandom_range(0, 31) == 0) b = ~b;
            step(1'b1, {$urandom, $urandom}, m, b);
        end

        // Asynchronous reset mid-slot at cycle 37 of a frame.
        while (t % FRAME != 37) step(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0);
        #6;
        rst_i = 1'b0;
        #1;
        chk("async_rst_seg", -1, {24'd0, seg_o}, 32'h0000_00FF);
        chk("async_rst_an",  -1, {24'd0, an_o},  32'h0000_00FF);
        chk("async_rst_frm", -1, {31'd0, frame_o}, 32'd0);
        repeat (2) step(1'b0, {$urandom, $urandom}, 8'hFF, 1'b1);

        // Blink from reset: frames 0-1 lit, 2-3 dark, blink dropped in frame 2.
        for (int i = 0; i < 6 * FRAME; i++)
            step(1'b1, (t % FRAME == 0) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFFF,
                 8'hFF, !(t >= 150 && t < 200));

        repeat (2) @(posedge clk_i);
        chk("scoreboard_drained", -1, sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
